// File: rtl/reg_file_ctx_pkg.sv
// rtl/reg_file_ctx_pkg.sv - shared register indices, flag bit positions and FSM states
package reg_file_ctx_pkg;

    localparam int R_Bits         = 14;
    localparam int R_BranchTarget = 15;

    // Carry is written and read back through the same flag bit.
    localparam int CarryInBit   = 0;
    localparam int CarryOutBit  = 0;
    localparam int BranchDirBit = 1;

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } state_t;

endpackage

// File: rtl/reg_file_ctx_if.sv
// rtl/reg_file_ctx_if.sv - register file access bus with master and slave views
interface reg_file_ctx_if #(
    parameter int W = 8,
    parameter int D = 4
);
    logic [D-1:0] RegSrc1;
    logic [D-1:0] RegSrc2;
    logic [D-1:0] RegDest;
    logic [W-1:0] WriteInput;
    logic         WriteReg;
    logic         CarryWrite;
    logic         CarryOutValue;
    logic         Save;
    logic         Restore;
    logic         Clear;
    logic [W-1:0] Out1;
    logic [W-1:0] Out2;
    logic         CarryInValue;
    logic         BranchDir;
    logic [W-1:0] BranchTargetRegister;
    logic         Busy;
    logic         ShadowValid;

    modport master (
        output RegSrc1, RegSrc2, RegDest, WriteInput, WriteReg,
               CarryWrite, CarryOutValue, Save, Restore, Clear,
        input  Out1, Out2, CarryInValue, BranchDir, BranchTargetRegister,
               Busy, ShadowValid
    );

    modport slave (
        input  RegSrc1, RegSrc2, RegDest, WriteInput, WriteReg,
               CarryWrite, CarryOutValue, Save, Restore, Clear,
        output Out1, Out2, CarryInValue, BranchDir, BranchTargetRegister,
               Busy, ShadowValid
    );

endinterface

// File: rtl/reg_file_ctx.sv
// rtl/reg_file_ctx.sv - register file with shadow context bank and sequenced clear
module reg_file_ctx
    import reg_file_ctx_pkg::*;
#(
    parameter int W         = 8,
    parameter int D         = 4,
    parameter int FLAGS_REG = R_Bits,
    parameter int BT_REG    = R_BranchTarget
) (
    input  logic          CLK,
    input  logic          init,
    reg_file_ctx_if.slave bus
);

    localparam int           NREGS     = 2 ** D;
    localparam logic [D-1:0] FLAGS_IDX = D'(FLAGS_REG);
    localparam logic [D-1:0] BT_IDX    = D'(BT_REG);
    localparam logic [D-1:0] LAST_IDX  = D'(NREGS - 1);

    logic [W-1:0] live   [NREGS];
    logic [W-1:0] shadow [NREGS];
    logic         shadow_valid;
    state_t       state;
    logic [D-1:0] ptr;
    logic         busy;

    assign busy = (state == CLEARING);

    always_ff @(posedge CLK or posedge init) begin
        if (init) begin
            for (int i = 0; i < NREGS; i++) begin
                live[i]   <= '0;
                shadow[i] <= '0;
            end
            shadow_valid <= 1'b0;
            state        <= IDLE;
            ptr          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Clear) begin
                        state <= CLEARING;
                        ptr   <= '0;
                    end else if (bus.Restore && shadow_valid) begin
                        live <= shadow;
                    end else begin
                        if (bus.Save) begin
                            shadow       <= live;
                            shadow_valid <= 1'b1;
                        end
                        if (bus.WriteReg) begin
                            live[bus.RegDest] <= bus.WriteInput;
                        end
                        // Later assignment wins, so the carry bit overrides a same-cycle flags write.
                        if (bus.CarryWrite) begin
                            live[FLAGS_IDX][CarryOutBit] <= bus.CarryOutValue;
                        end
                    end
                end
                CLEARING: begin
                    live[ptr] <= '0;
                    ptr       <= ptr + 1'b1;
                    if (ptr == LAST_IDX) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Out1 = (!busy && bus.WriteReg && (bus.RegDest == bus.RegSrc1))
                      ? bus.WriteInput : live[bus.RegSrc1];
    assign bus.Out2 = (!busy && bus.WriteReg && (bus.RegDest == bus.RegSrc2))
                      ? bus.WriteInput : live[bus.RegSrc2];

    assign bus.CarryInValue         = live[FLAGS_IDX][CarryInBit];
    assign bus.BranchDir            = live[FLAGS_IDX][BranchDirBit];
    assign bus.BranchTargetRegister = live[BT_IDX];
    assign bus.Busy                 = busy;
    assign bus.ShadowValid          = shadow_valid;

endmodule
